tgl_hs_receiver: RTL and testbench

Receiving end of the two-phase (toggle) request/acknowledge link, whose transmitter's request line is a toggle flip-flop. The block synchronizes the incoming request toggle into `clk_in`, captures the bundled data word, presents it to a local consumer with a valid/ready handshake, and returns an acknowledge toggle once the word is consumed. It also counts accepted transfers and flags protocol violations.

---
 rtl/tgl_hs_receiver.sv | 100 ++++++++++
 tb/tb_tgl_hs_receiver.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/tgl_hs_receiver.sv
// Receiving end of a two-phase toggle request/acknowledge link.
// Synchronizes the request toggle, captures the bundled word, hands it off via valid/ready and returns an ack toggle.
module tgl_hs_receiver #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic                  req_tgl_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  ack_tgl_out,
    output logic                  valid_out,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  ready_in,
    output logic [CNT_WIDTH-1:0]  count_out,
    output logic                  error_out
);

    typedef enum logic {
        IDLE,
        VALID
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [SYNC_STAGES-1:0] sync;
    logic                   req_s;
    logic                   req_seen;
    logic                   req_seen_next;
    logic                   req_edge;
    logic                   valid_next;
    logic                   ack_next;
    logic                   error_next;
    logic [DATA_WIDTH-1:0]  data_next;
    logic [CNT_WIDTH-1:0]   count_next;

    assign req_s    = sync[SYNC_STAGES-1];
    assign req_edge = req_s ^ req_seen;

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            sync        <= '0;
            req_seen    <= 1'b0;
            state       <= IDLE;
            valid_out   <= 1'b0;
            ack_tgl_out <= 1'b0;
            data_out    <= '0;
            count_out   <= '0;
            error_out   <= 1'b0;
        end else begin
            sync        <= {sync[SYNC_STAGES-2:0], req_tgl_in};
            req_seen    <= req_seen_next;
            state       <= state_next;
            valid_out   <= valid_next;
            ack_tgl_out <= ack_next;
            data_out    <= data_next;
            count_out   <= count_next;
            error_out   <= error_next;
        end
    end

    // A request edge while a word is still pending is a protocol error; it is
    // absorbed into req_seen so it never produces a second capture.
    always_comb begin
        state_next    = state;
        req_seen_next = req_seen;
        valid_next    = valid_out;
        ack_next      = ack_tgl_out;
        data_next     = data_out;
        count_next    = count_out;
        error_next    = error_out;
        case (state)
            IDLE: begin
                if (req_edge) begin
                    data_next     = data_in;
                    valid_next    = 1'b1;
                    req_seen_next = req_s;
                    state_next    = VALID;
                end
            end
            VALID: begin
                if (valid_out && ready_in) begin
                    valid_next = 1'b0;
                    ack_next   = ~ack_tgl_out;
                    if (count_out != '1) begin
                        count_next = count_out + CNT_WIDTH'(1);
                    end
                    state_next = IDLE;
                end
                if (req_edge) begin
                    error_next    = 1'b1;
                    req_seen_next = req_s;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_tgl_hs_receiver.sv
// Directed bench for tgl_hs_receiver: latency, back-pressure, ordering, violation, saturation and reset.
module tb_tgl_hs_receiver;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic        req_tgl_in;
    logic [7:0]  data_in;
    logic        ready_in;
    logic        ack_tgl_out;
    logic        valid_out;
    logic [7:0]  data_out;
    logic [15:0] count_out;
    logic        error_out;
    logic        sat_ack;
    logic        sat_valid;
    logic [7:0]  sat_data;
    logic [1:0]  sat_count;
    logic        sat_error;

    int tests_run = 0;
    int tests_failed = 0;

    tgl_hs_receiver #(.DATA_WIDTH(8), .SYNC_STAGES(2), .CNT_WIDTH(16)) dut (
        .clk_in(clk_in), .reset_in(reset_in), .req_tgl_in(req_tgl_in), .data_in(data_in),
        .ack_tgl_out(ack_tgl_out), .valid_out(valid_out), .data_out(data_out),
        .ready_in(ready_in), .count_out(count_out), .error_out(error_out)
    );

    tgl_hs_receiver #(.DATA_WIDTH(8), .SYNC_STAGES(2), .CNT_WIDTH(2)) dut_sat (
        .clk_in(clk_in), .reset_in(reset_in), .req_tgl_in(req_tgl_in), .data_in(data_in),
        .ack_tgl_out(sat_ack), .valid_out(sat_valid), .data_out(sat_data),
        .ready_in(ready_in), .count_out(sat_count), .error_out(sat_error)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk_in);
    endtask

    task automatic applyStimulus(input logic rst, input logic req, input logic [7:0] d, input logic rdy);
        reset_in   = rst;
        req_tgl_in = req;
        data_in    = d;
        ready_in   = rdy;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, observed, expected);
        end
    endtask

    // Toggle the request with word d, wait (bounded) for capture, check it,
    // then let the held-high ready accept it and check the ack toggle.
    task automatic runTransfer(input logic [7:0] d, input logic exp_ack);
        int waited = 0;
        applyStimulus(1'b0, ~req_tgl_in, d, 1'b1);
        while (!valid_out && waited < 10) begin
            tick(1);
            waited++;
        end
        checkOutput("xfer_valid_seen", valid_out, 1'b1);
        checkOutput("xfer_data", data_out, d);
        tick(1);
        checkOutput("xfer_ack", ack_tgl_out, exp_ack);
        checkOutput("xfer_valid_fall", valid_out, 1'b0);
    endtask

    initial begin
        // Reset
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        tick(2);
        checkOutput("rst_valid", valid_out, 1'b0);
        checkOutput("rst_ack", ack_tgl_out, 1'b0);
        checkOutput("rst_data", data_out, 8'h00);
        checkOutput("rst_count", count_out, 16'd0);
        checkOutput("rst_error", error_out, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        tick(3);
        checkOutput("idle_valid", valid_out, 1'b0);
        checkOutput("idle_ack", ack_tgl_out, 1'b0);
        checkOutput("idle_count", count_out, 16'd0);

        // Single transfer with latency
        applyStimulus(1'b0, 1'b1, 8'hA5, 1'b1);
        tick(1);
        checkOutput("lat_n_valid", valid_out, 1'b0);
        tick(1);
        checkOutput("lat_n1_valid", valid_out, 1'b0);
        tick(1);
        checkOutput("lat_n2_valid", valid_out, 1'b1);
        checkOutput("lat_n2_data", data_out, 8'hA5);
        checkOutput("lat_n2_ack", ack_tgl_out, 1'b0);
        tick(1);
        checkOutput("lat_n3_ack", ack_tgl_out, 1'b1);
        checkOutput("lat_n3_valid", valid_out, 1'b0);
        checkOutput("lat_n3_count", count_out, 16'd1);
        checkOutput("lat_hold_data", data_out, 8'hA5);

        // Back-pressure
        applyStimulus(1'b0, 1'b0, 8'h3C, 1'b0);
        tick(3);
        checkOutput("bp_capture", valid_out, 1'b1);
        tick(10);
        checkOutput("bp_valid", valid_out, 1'b1);
        checkOutput("bp_data", data_out, 8'h3C);
        checkOutput("bp_ack", ack_tgl_out, 1'b1);
        checkOutput("bp_count", count_out, 16'd1);
        ready_in = 1'b1;
        tick(1);
        checkOutput("bp_rel_ack", ack_tgl_out, 1'b0);
        checkOutput("bp_rel_count", count_out, 16'd2);
        checkOutput("bp_rel_valid", valid_out, 1'b0);

        // Back-to-back transfers from a fresh reset
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
        tick(1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        tick(1);
        runTransfer(8'h01, 1'b1);
        runTransfer(8'h02, 1'b0);
        runTransfer(8'h03, 1'b1);
        runTransfer(8'h04, 1'b0);
        checkOutput("b2b_ack", ack_tgl_out, 1'b0);
        checkOutput("b2b_count", count_out, 16'd4);
        checkOutput("b2b_error", error_out, 1'b0);
        checkOutput("b2b_sat_count", sat_count, 2'b11);

        // Protocol violation
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        tick(1);
        applyStimulus(1'b0, 1'b1, 8'h11, 1'b0);
        tick(3);
        checkOutput("viol_first", data_out, 8'h11);
        checkOutput("viol_no_err_yet", error_out, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h22, 1'b0);
        tick(3);
        checkOutput("viol_error", error_out, 1'b1);
        checkOutput("viol_data", data_out, 8'h11);
        checkOutput("viol_valid", valid_out, 1'b1);
        ready_in = 1'b1;
        tick(1);
        checkOutput("viol_accept_count", count_out, 16'd1);
        checkOutput("viol_accept_ack", ack_tgl_out, 1'b1);
        tick(5);
        checkOutput("viol_no_recapture", valid_out, 1'b0);
        checkOutput("viol_data_hold", data_out, 8'h11);
        checkOutput("viol_sticky", error_out, 1'b1);
        checkOutput("viol_count_hold", count_out, 16'd1);

        // Saturation with a 2-bit counter
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
        tick(1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        tick(1);
        runTransfer(8'h10, 1'b1);
        runTransfer(8'h20, 1'b0);
        runTransfer(8'h30, 1'b1);
        runTransfer(8'h40, 1'b0);
        runTransfer(8'h50, 1'b1);
        checkOutput("sat_count", sat_count, 2'b11);
        checkOutput("sat_ack", sat_ack, 1'b1);
        checkOutput("sat_valid", sat_valid, 1'b0);
        checkOutput("sat_main_count", count_out, 16'd5);
        checkOutput("sat_error", sat_error, 1'b0);

        // Reset mid-transfer
        applyStimulus(1'b0, 1'b0, 8'h5A, 1'b0);
        tick(3);
        checkOutput("mid_pending", valid_out, 1'b1);
        checkOutput("mid_pending_data", data_out, 8'h5A);
        applyStimulus(1'b1, 1'b0, 8'h5A, 1'b0);
        tick(1);
        checkOutput("mid_rst_valid", valid_out, 1'b0);
        checkOutput("mid_rst_ack", ack_tgl_out, 1'b0);
        checkOutput("mid_rst_data", data_out, 8'h00);
        checkOutput("mid_rst_count", count_out, 16'd0);
        checkOutput("mid_rst_sat_count", sat_count, 2'b00);
        applyStimulus(1'b0, 1'b0, 8'h5A, 1'b1);
        tick(4);
        checkOutput("mid_after_valid", valid_out, 1'b0);
        checkOutput("mid_after_ack", ack_tgl_out, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
